// File: rtl/axi_ctrl_pkg.sv
// Shared types and constants for the AXI write-command arbiter: FSM state
// encoding, burst setup types and the fixed data/length widths.
package axi_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BURST = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_e;

    localparam logic [1:0] ADDR_FIRST = 2'd0;
    localparam logic [1:0] DATA_FIRST = 2'd1;
    localparam logic [1:0] DATA_ADDR  = 2'd2;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;

    // Index width for a requester vector; never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_write_arbiter_if.sv
// Requester-side and master-side signal bundle of the AXI write-command arbiter.
// The slave modport is the arbiter's view; master is the view of the surroundings.
interface axi_write_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32
) ();
    import axi_ctrl_pkg::*;

    logic [NUM_REQ-1:0]            REQ_VALID_I;
    logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_ADDR_I;
    logic [NUM_REQ*CNT_W-1:0]      REQ_LEN_I;
    logic [NUM_REQ*2-1:0]          REQ_SETUP_I;
    logic [NUM_REQ*DATA_W-1:0]     REQ_DATA_I;

    logic [NUM_REQ-1:0]            GRANT_O;
    logic [NUM_REQ-1:0]            DATA_ACK_O;
    logic [NUM_REQ-1:0]            DONE_O;

    logic                          MST_WRITE_O;
    logic [1:0]                    MST_SETUP_O;
    logic [CNT_W-1:0]              MST_LEN_O;
    logic [ADDR_WIDTH-1:0]         MST_ADDR_O;
    logic [DATA_W-1:0]             MST_DATA_O;
    logic                          MST_READY_I;
    logic                          MST_STARTED_I;
    logic                          MST_BEAT_I;

    logic                          ERR_O;

    modport slave (
        input  REQ_VALID_I, REQ_ADDR_I, REQ_LEN_I, REQ_SETUP_I, REQ_DATA_I,
        input  MST_READY_I, MST_STARTED_I, MST_BEAT_I,
        output GRANT_O, DATA_ACK_O, DONE_O,
        output MST_WRITE_O, MST_SETUP_O, MST_LEN_O, MST_ADDR_O, MST_DATA_O,
        output ERR_O
    );

    modport master (
        output REQ_VALID_I, REQ_ADDR_I, REQ_LEN_I, REQ_SETUP_I, REQ_DATA_I,
        output MST_READY_I, MST_STARTED_I, MST_BEAT_I,
        input  GRANT_O, DATA_ACK_O, DONE_O,
        input  MST_WRITE_O, MST_SETUP_O, MST_LEN_O, MST_ADDR_O, MST_DATA_O,
        input  ERR_O
    );

endinterface

// File: rtl/axi_write_arbiter_rr_arbiter.sv
// Round-robin requester selection: searches upward from the index after the
// pointer, wrapping, and returns a one-hot grant plus its binary index.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               any_o
);

    always_comb begin
        int k;
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        k         = 0;
        // Offset NUM_REQ lands back on the pointer itself, so it is checked last.
        for (int i = 1; i <= NUM_REQ; i++) begin
            k = (int'(ptr_i) + i) % NUM_REQ;
            if (!any_o && req_i[k]) begin
                any_o     = 1'b1;
                gnt_o[k]  = 1'b1;
                gnt_idx_o = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/axi_write_arbiter.sv
// Arbitrates NUM_REQ burst requesters onto one AXI write-command master:
// round-robin grant, command issue, beat counting, drain and error detection.
module axi_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                CLK_I,
    input  logic                RST_I,
    axi_write_arbiter_if.slave  bus
);
    import axi_ctrl_pkg::*;

    localparam int IDX_W = idx_width(NUM_REQ);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic               chk_q, chk_d;
    logic               err_q, err_d;
    logic               write_q, write_d;

    logic               ack;
    logic               done;
    logic               out_en;

    logic [NUM_REQ-1:0] rr_gnt;
    logic [IDX_W-1:0]   rr_idx;
    logic               rr_any;

    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [CNT_W-1:0]      sel_len;
    logic [1:0]            sel_setup;
    logic [DATA_W-1:0]     sel_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req_i     (bus.REQ_VALID_I),
        .ptr_i     (ptr_q),
        .gnt_o     (rr_gnt),
        .gnt_idx_o (rr_idx),
        .any_o     (rr_any)
    );

    assign sel_addr  = bus.REQ_ADDR_I[int'(gidx_q)*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_len   = bus.REQ_LEN_I[int'(gidx_q)*CNT_W +: CNT_W];
    assign sel_setup = bus.REQ_SETUP_I[int'(gidx_q)*2 +: 2];
    assign sel_data  = bus.REQ_DATA_I[int'(gidx_q)*DATA_W +: DATA_W];

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        chk_d   = 1'b0;
        err_d   = err_q;
        write_d = write_q;
        ack     = 1'b0;
        done    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rr_any) begin
                    grant_d = rr_gnt;
                    gidx_d  = rr_idx;
                    ptr_d   = rr_idx;
                    write_d = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.MST_READY_I && write_q) begin
                    ack     = 1'b1;
                    cnt_d   = '0;
                    len_d   = sel_len;
                    chk_d   = 1'b1;
                    write_d = 1'b0;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                // The master must confirm the command in the first burst cycle.
                if (chk_q && !bus.MST_STARTED_I) begin
                    err_d   = 1'b1;
                    grant_d = '0;
                    state_d = ST_IDLE;
                end else if (bus.MST_BEAT_I) begin
                    if (cnt_q == len_q) begin
                        done    = 1'b1;
                        grant_d = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        ack   = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (bus.MST_READY_I) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            cnt_q   <= '0;
            chk_q   <= 1'b0;
            err_q   <= 1'b0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            chk_q   <= chk_d;
            err_q   <= err_d;
            write_q <= write_d;
        end
    end

    // Index and length are only meaningful while a grant is held.
    always_ff @(posedge CLK_I) begin
        gidx_q <= gidx_d;
        len_q  <= len_d;
    end

    // Every output is held at zero while reset is applied.
    assign out_en          = !RST_I;
    assign bus.GRANT_O     = out_en ? grant_q : '0;
    assign bus.DATA_ACK_O  = (out_en && ack) ? grant_q : '0;
    assign bus.DONE_O      = (out_en && done) ? grant_q : '0;
    assign bus.MST_WRITE_O = out_en && write_q;
    assign bus.MST_ADDR_O  = (out_en && write_q) ? sel_addr : '0;
    assign bus.MST_LEN_O   = (out_en && write_q) ? sel_len : '0;
    assign bus.MST_SETUP_O = (out_en && write_q) ? sel_setup : '0;
    assign bus.MST_DATA_O  = (out_en && (|grant_q)) ? sel_data : '0;
    assign bus.ERR_O       = out_en && err_q;

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Bench for axi_write_arbiter: vector table plus hand sequences, with a
// requester/master model and an expected-grant scoreboard.
module tb_axi_write_arbiter;
    import axi_ctrl_pkg::*;

    localparam int NR = 4;
    localparam int AW = 32;

    logic clk;
    logic rst;

    axi_write_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW)) bus ();

    axi_write_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW)) dut (
        .CLK_I (clk),
        .RST_I (rst),
        .bus   (bus)
    );

    typedef struct {
        logic            rst_first;
        logic [3:0]      mask;
        logic [7:0]      len;
        logic [1:0]      setup;
        logic [31:0]     addr;
        logic            gaps;
        int              n_exp;
        logic [3:0][1:0] order;
    } vec_t;

    typedef struct {
        int   idx;
        int   len;
        logic err;
    } exp_t;

    vec_t vecs[6];
    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0]   addr_r[NR];
    logic [31:0]   data_r[NR];
    logic [7:0]    len_r[NR];
    logic [1:0]    setup_r[NR];
    logic [NR-1:0] valid_r;
    logic [NR-1:0] ack_pend;
    logic          rst_r;
    logic          inject_err;
    logic          gaps;
    logic          acc_prev;
    logic          prev_any;
    logic          had_grant;
    logic          err_prev;
    int            beats_left;
    int            acks;
    int            beats;
    int            cur;
    int            gap_cyc;
    int            done_cnt;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_inputs();
        bus.REQ_VALID_I = valid_r;
        for (int i = 0; i < NR; i++) begin
            bus.REQ_ADDR_I[i*AW +: AW]  = addr_r[i];
            bus.REQ_LEN_I[i*8 +: 8]     = len_r[i];
            bus.REQ_SETUP_I[i*2 +: 2]   = setup_r[i];
            bus.REQ_DATA_I[i*32 +: 32]  = data_r[i];
        end
        bus.MST_READY_I = 1'b1;
    endtask

    // One clock: drive at the falling edge, sample 1 ns later, update the model.
    task automatic step();
        logic beat_now;
        exp_t e;
        @(negedge clk);
        rst = rst_r;
        for (int i = 0; i < NR; i++) begin
            if (ack_pend[i]) data_r[i] = data_r[i] + 32'd1;
        end
        ack_pend = '0;
        bus.MST_STARTED_I = acc_prev && !inject_err;
        beat_now = (beats_left > 0) && (!gaps || $urandom_range(0, 2) != 0);
        bus.MST_BEAT_I = beat_now;
        drive_inputs();
        #1;
        acc_prev = 1'b0;

        check("grant_onehot", 64'($countones(bus.GRANT_O) <= 1), 64'd1);
        if (bus.GRANT_O != '0 && !prev_any) begin
            if (had_grant) check("idle_gap", 64'(gap_cyc >= 1), 64'd1);
            had_grant = 1'b1;
            valid_r = valid_r & ~bus.GRANT_O;
        end
        gap_cyc  = (bus.GRANT_O == '0) ? gap_cyc + 1 : 0;
        prev_any = |bus.GRANT_O;

        if (bus.MST_WRITE_O && bus.MST_READY_I) begin
            if (sb.size() == 0) begin
                check("unexpected_grant", bus.GRANT_O, 0);
            end else begin
                cur = sb[0].idx;
                check("grant_idx", bus.GRANT_O, 64'(1) << cur);
                check("issue_addr", bus.MST_ADDR_O, addr_r[cur]);
                check("issue_len", bus.MST_LEN_O, len_r[cur]);
                check("issue_setup", bus.MST_SETUP_O, setup_r[cur]);
                check("issue_data", bus.MST_DATA_O, data_r[cur]);
                acc_prev   = 1'b1;
                beats_left = inject_err ? 0 : int'(len_r[cur]) + 1;
                acks       = 0;
                beats      = 0;
            end
        end
        if (bus.DATA_ACK_O != '0) begin
            acks++;
            check("ack_target", bus.DATA_ACK_O, 64'(1) << cur);
        end
        ack_pend = bus.DATA_ACK_O;

        if (beat_now) begin
            beats++;
            beats_left--;
            if (!rst_r) check("beat_data", bus.MST_DATA_O, data_r[cur]);
        end

        if (bus.DONE_O != '0) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_done", bus.DONE_O, 0);
            end else begin
                e = sb.pop_front();
                check("done_idx", bus.DONE_O, 64'(1) << e.idx);
                check("done_acks", 64'(acks), 64'(e.len + 1));
                check("done_beats", 64'(beats), 64'(e.len + 1));
                check("done_not_err", e.err, 0);
            end
        end

        if (bus.ERR_O && !err_prev) begin
            if (sb.size() == 0) begin
                check("unexpected_err", bus.ERR_O, 0);
            end else begin
                e = sb.pop_front();
                check("err_expected", e.err, 1);
                check("err_grant_dropped", bus.GRANT_O, 0);
            end
        end
        err_prev = bus.ERR_O;
    endtask

    task automatic wait_sb(input int budget);
        for (int c = 0; c < budget && sb.size() != 0; c++) step();
        check("drain_timeout", 64'(sb.size()), 0);
        sb.delete();
        repeat (3) step();
    endtask

    task automatic do_reset();
        rst_r = 1'b1;
        valid_r = '0;
        beats_left = 0;
        acc_prev = 1'b0;
        ack_pend = '0;
        sb.delete();
        step();
        step();
        check("rst_grant", bus.GRANT_O, 0);
        check("rst_write", bus.MST_WRITE_O, 0);
        check("rst_err", bus.ERR_O, 0);
        rst_r = 1'b0;
        step();
        check("post_rst_grant", bus.GRANT_O, 0);
        check("post_rst_ack", bus.DATA_ACK_O, 0);
        check("post_rst_done", bus.DONE_O, 0);
        check("post_rst_write", bus.MST_WRITE_O, 0);
        check("post_rst_addr", bus.MST_ADDR_O, 0);
        check("post_rst_data", bus.MST_DATA_O, 0);
        check("post_rst_err", bus.ERR_O, 0);
        had_grant = 1'b0;
        gap_cyc = 0;
    endtask

    task automatic load_req(input int i, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] setup);
        addr_r[i]  = addr;
        len_r[i]   = len;
        setup_r[i] = setup;
        data_r[i]  = 32'hD000_0000 | (32'(i) << 16);
    endtask

    task automatic run_vector(input vec_t v);
        exp_t e;
        if (v.rst_first) do_reset();
        gaps = v.gaps;
        inject_err = 1'b0;
        for (int i = 0; i < NR; i++) begin
            if (v.mask[i]) load_req(i, v.addr + (32'(i) << 12), v.len, v.setup);
        end
        for (int k = 0; k < v.n_exp; k++) begin
            e.idx = int'(v.order[k]);
            e.len = int'(v.len);
            e.err = 1'b0;
            sb.push_back(e);
        end
        valid_r = valid_r | v.mask;
        wait_sb(4000);
    endtask

    initial begin
        exp_t e;
        rst = 1'b1;
        rst_r = 1'b1;
        inject_err = 1'b0;
        gaps = 1'b0;
        acc_prev = 1'b0;
        prev_any = 1'b0;
        had_grant = 1'b0;
        err_prev = 1'b0;
        beats_left = 0;
        acks = 0;
        beats = 0;
        cur = 0;
        gap_cyc = 0;
        done_cnt = 0;
        valid_r = '0;
        ack_pend = '0;
        for (int i = 0; i < NR; i++) load_req(i, 32'h0, 8'h0, ADDR_FIRST);
        bus.MST_STARTED_I = 1'b0;
        bus.MST_BEAT_I = 1'b0;
        drive_inputs();

        vecs[0] = '{1'b1, 4'b0001, 8'd3,   ADDR_FIRST, 32'h0000_0100, 1'b0, 1, {2'd0, 2'd0, 2'd0, 2'd0}};
        vecs[1] = '{1'b1, 4'b1111, 8'd0,   DATA_ADDR,  32'h0000_2000, 1'b0, 4, {2'd3, 2'd2, 2'd1, 2'd0}};
        vecs[2] = '{1'b0, 4'b0010, 8'd1,   ADDR_FIRST, 32'h0000_0300, 1'b1, 1, {2'd0, 2'd0, 2'd0, 2'd1}};
        vecs[3] = '{1'b0, 4'b0110, 8'd2,   DATA_FIRST, 32'h0000_0400, 1'b0, 2, {2'd0, 2'd0, 2'd1, 2'd2}};
        vecs[4] = '{1'b0, 4'b1000, 8'd255, DATA_FIRST, 32'h0000_0800, 1'b0, 1, {2'd0, 2'd0, 2'd0, 2'd3}};
        vecs[5] = '{1'b0, 4'b0011, 8'd5,   DATA_ADDR,  32'h0000_0A00, 1'b1, 2, {2'd0, 2'd0, 2'd1, 2'd0}};

        do_reset();
        for (int v = 0; v < 6; v++) run_vector(vecs[v]);

        // Reset applied on the second beat of an eight-beat burst.
        gaps = 1'b0;
        load_req(2, 32'h0000_5000, 8'd7, ADDR_FIRST);
        e.idx = 2; e.len = 7; e.err = 1'b0;
        sb.push_back(e);
        valid_r[2] = 1'b1;
        beats = 0;
        for (int c = 0; c < 40 && beats < 1; c++) step();
        check("midburst_reached", 64'(beats), 1);
        sb.delete();
        done_cnt = 0;
        rst_r = 1'b1;
        step();
        check("midrst_done_during", bus.DONE_O, 0);
        check("midrst_grant_during", bus.GRANT_O, 0);
        rst_r = 1'b0;
        beats_left = 0;
        acc_prev = 1'b0;
        valid_r = '0;
        ack_pend = '0;
        step();
        check("midrst_grant_after", bus.GRANT_O, 0);
        check("midrst_ack_after", bus.DATA_ACK_O, 0);
        check("midrst_write_after", bus.MST_WRITE_O, 0);
        repeat (5) step();
        check("midrst_no_done", 64'(done_cnt), 0);

        // Master never confirms the accepted command.
        load_req(1, 32'h0000_6000, 8'd4, DATA_FIRST);
        e.idx = 1; e.len = 4; e.err = 1'b1;
        sb.push_back(e);
        inject_err = 1'b1;
        done_cnt = 0;
        valid_r[1] = 1'b1;
        wait_sb(50);
        check("err_sticky", bus.ERR_O, 1);
        check("err_grant", bus.GRANT_O, 0);
        check("err_write", bus.MST_WRITE_O, 0);
        check("err_no_done", 64'(done_cnt), 0);

        // A normal burst afterwards still completes and the error stays set.
        inject_err = 1'b0;
        load_req(0, 32'h0000_7000, 8'd0, ADDR_FIRST);
        e.idx = 0; e.len = 0; e.err = 1'b0;
        sb.push_back(e);
        valid_r[0] = 1'b1;
        wait_sb(50);
        check("err_still_sticky", bus.ERR_O, 1);
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
